// File: rtl/ezp_pkg.sv
// ---------------------------------------------------------------
// ezp_pkg : shared states, error codes and header offsets
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package ezp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_START = 2'd0,
    ERR_LEN   = 2'd1,
    ERR_CHK   = 2'd2,
    ERR_END   = 2'd3
  } err_e;

  localparam int OFS_TYPE = 1;
  localparam int OFS_LEN  = 2;
  localparam int OFS_PD   = 3;

endpackage

`default_nettype wire

// File: rtl/ezp_deframer_if.sv
// ---------------------------------------------------------------
// ezp_deframer_if : frame-in / beat-out handshake bundle
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface ezp_deframer_if #(
  parameter int MAX_PKTLEN = 13,
  parameter int OUT_BYTES  = 2
);
  logic [8*MAX_PKTLEN-1:0] i_data;
  logic                    i_valid;
  logic                    i_ready;
  logic [8*OUT_BYTES-1:0]  o_data;
  logic [OUT_BYTES-1:0]    o_keep;
  logic                    o_last;
  logic [7:0]              o_type;
  logic                    o_valid;
  logic                    o_ready;

  modport master (
    output i_data, i_valid, o_ready,
    input  i_ready, o_data, o_keep, o_last, o_type, o_valid
  );

  modport slave (
    input  i_data, i_valid, o_ready,
    output i_ready, o_data, o_keep, o_last, o_type, o_valid
  );
endinterface

`default_nettype wire

// File: rtl/ezp_xsum.sv
// ---------------------------------------------------------------
// ezp_xsum : XOR of TYPE, LEN and the first LEN payload bytes
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module ezp_xsum #(
  parameter int MAX_PD_LEN = 8
) (
  input  logic [7:0]              i_type,
  input  logic [7:0]              i_len,
  input  logic [8*MAX_PD_LEN-1:0] i_payload,
  output logic [7:0]              o_xsum
);
  always_comb begin
    o_xsum = i_type ^ i_len;
    for (int k = 0; k < MAX_PD_LEN; k++) begin
      if (8'(k) < i_len) o_xsum = o_xsum ^ i_payload[8*k +: 8];
    end
  end
endmodule

`default_nettype wire

// File: rtl/ezp_deframer.sv
// ---------------------------------------------------------------
// ezp_deframer : validates a parallel frame, streams its payload
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module ezp_deframer
  import ezp_pkg::*;
#(
  parameter logic [7:0] START_BYTE = 8'hAA,
  parameter logic [7:0] END_BYTE   = 8'h55,
  parameter int         MAX_PD_LEN = 8,
  parameter int         OUT_BYTES  = 2,
  parameter int         MAX_PKTLEN = MAX_PD_LEN + 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ezp_deframer_if.slave        bus,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [15:0]          drop_cnt
);
  state_e                  state_q, state_d;
  logic [8*MAX_PKTLEN-1:0] frame_q, frame_d;
  logic [7:0]              pos_q, pos_d;
  logic [8*OUT_BYTES-1:0]  data_q, data_d;
  logic [OUT_BYTES-1:0]    keep_q, keep_d;
  logic                    last_q, last_d;
  logic [7:0]              type_q, type_d;
  err_e                    err_code_q, err_code_d;
  logic                    err_pulse_q, err_pulse_d;
  logic [15:0]             drop_q, drop_d;

  logic [7:0]              w_type, w_len, w_len_c, w_chk, w_end, w_xsum;
  logic [8*MAX_PD_LEN-1:0] w_payload;
  logic                    w_len_ok, w_bad;
  err_e                    w_code;
  logic [7:0]              w_pos_base, w_rem;
  logic [8*OUT_BYTES-1:0]  w_src, w_beat_data;
  logic [OUT_BYTES-1:0]    w_beat_keep;
  logic                    w_beat_last;

  assign w_type    = frame_q[8*OFS_TYPE +: 8];
  assign w_len     = frame_q[8*OFS_LEN +: 8];
  assign w_payload = frame_q[8*OFS_PD +: 8*MAX_PD_LEN];
  assign w_len_ok  = (w_len <= 8'(MAX_PD_LEN));
  // Clamping keeps the CHK/END lookup inside the frame when LEN is illegal.
  assign w_len_c   = w_len_ok ? w_len : 8'(MAX_PD_LEN);

  always_comb begin
    w_chk = '0;
    w_end = '0;
    for (int k = 0; k <= MAX_PD_LEN; k++) begin
      if (8'(k) == w_len_c) begin
        w_chk = frame_q[8*(k+OFS_PD) +: 8];
        w_end = frame_q[8*(k+OFS_PD+1) +: 8];
      end
    end
  end

  ezp_xsum #(.MAX_PD_LEN(MAX_PD_LEN)) u_xsum (
    .i_type    (w_type),
    .i_len     (w_len),
    .i_payload (w_payload),
    .o_xsum    (w_xsum)
  );

  always_comb begin
    w_bad  = 1'b1;
    w_code = ERR_START;
    if (frame_q[7:0] != START_BYTE) w_code = ERR_START;
    else if (!w_len_ok)             w_code = ERR_LEN;
    else if (w_chk != w_xsum)       w_code = ERR_CHK;
    else if (w_end != END_BYTE)     w_code = ERR_END;
    else                            w_bad  = 1'b0;
  end

  // Beat under construction: the first beat from CHECK, the next one from STREAM.
  assign w_pos_base  = (state_q == ST_CHECK) ? 8'd0 : pos_q + 8'(OUT_BYTES);
  assign w_rem       = w_len - w_pos_base;
  assign w_src       = (8*OUT_BYTES)'(w_payload >> {w_pos_base, 3'b000});
  assign w_beat_last = (w_rem <= 8'(OUT_BYTES));

  always_comb begin
    w_beat_data = '0;
    w_beat_keep = '0;
    for (int l = 0; l < OUT_BYTES; l++) begin
      if (8'(l) < w_rem) begin
        w_beat_data[8*l +: 8] = w_src[8*l +: 8];
        w_beat_keep[l]        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    pos_d       = pos_q;
    data_d      = data_q;
    keep_d      = keep_q;
    last_d      = last_q;
    type_d      = type_q;
    err_code_d  = err_code_q;
    err_pulse_d = 1'b0;
    drop_d      = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          frame_d = bus.i_data;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_bad) begin
          err_code_d  = w_code;
          err_pulse_d = 1'b1;
          drop_d      = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_STREAM;
          pos_d   = 8'd0;
          data_d  = w_beat_data;
          keep_d  = w_beat_keep;
          last_d  = w_beat_last;
          type_d  = w_type;
        end
      end
      ST_STREAM: begin
        if (bus.o_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
          end else begin
            pos_d  = w_pos_base;
            data_d = w_beat_data;
            keep_d = w_beat_keep;
            last_d = w_beat_last;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      pos_q       <= '0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      type_q      <= '0;
      err_code_q  <= ERR_START;
      err_pulse_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      pos_q       <= pos_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      type_q      <= type_d;
      err_code_q  <= err_code_d;
      err_pulse_q <= err_pulse_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.i_ready = (state_q == ST_IDLE);
  assign bus.o_valid = (state_q == ST_STREAM);
  assign bus.o_data  = data_q;
  assign bus.o_keep  = keep_q;
  assign bus.o_last  = last_q;
  assign bus.o_type  = type_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;
  assign drop_cnt    = drop_q;
endmodule

`default_nettype wire
